// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, constants and helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_e;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] KEY_IDLE  = 4'b1111;

    function automatic logic one_cold4(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    // Walking zero moves one bit towards the MSB and wraps.
    function automatic logic [3:0] rotate_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/sync2_zyq.sv
// rtl/sync2_zyq.sv - 4-bit two-flop synchroniser, resets to all-ones (no key)
module sync2_zyq
    import keypad_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] s1_q;
    logic [3:0] s2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= KEY_IDLE;
            s2_q <= KEY_IDLE;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/keypad_scan_zyq.sv
// rtl/keypad_scan_zyq.sv - 4x4 keypad column scanner with press/release debounce
// Optional key_strobe output enabled by KEYSCAN_STROBE_EN.
module keypad_scan_zyq
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 8,
    parameter int CW           = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] kp_row,
    output logic [3:0] kp_col,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       valid
`ifdef KEYSCAN_STROBE_EN
    ,
    output logic       key_strobe
`endif
);

    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_ZERO   = '0;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    state_e        state_q, state_d;
    logic [3:0]    kp_col_q, kp_col_d;
    logic [3:0]    cap_row_q, cap_row_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] deb_q, deb_d;
    logic [3:0]    rs;

    sync2_zyq u_sync (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .d_i    (kp_row),
        .q_o    (rs)
    );

    logic scan_hit;
    logic deb_hit;
    logic match_cap;
    logic rs_idle;
    logic accept;

    assign scan_hit  = (dwell_q == DWELL_LAST);
    assign deb_hit   = (deb_q == DEB_LAST);
    assign match_cap = (rs == cap_row_q);
    assign rs_idle   = (rs == KEY_IDLE);
    assign accept    = (state_q == DEBOUNCE) && match_cap && deb_hit;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= SCAN;
            kp_col_q  <= COL_RESET;
            cap_row_q <= KEY_IDLE;
            row_q     <= KEY_IDLE;
            col_q     <= KEY_IDLE;
            valid_q   <= 1'b0;
            dwell_q   <= CNT_ZERO;
            deb_q     <= CNT_ZERO;
        end else begin
            state_q   <= state_d;
            kp_col_q  <= kp_col_d;
            cap_row_q <= cap_row_d;
            row_q     <= row_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            dwell_q   <= dwell_d;
            deb_q     <= deb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:     if (scan_hit && one_cold4(rs)) state_d = DEBOUNCE;
            DEBOUNCE: begin
                if (!match_cap)   state_d = SCAN;
                else if (deb_hit) state_d = HOLD;
            end
            HOLD:     if (rs_idle && deb_hit) state_d = SCAN;
            default:  state_d = SCAN;
        endcase
    end

    // Counters, column drive and presented key; debounce counter is reused for press and release.
    always_comb begin
        kp_col_d  = kp_col_q;
        cap_row_d = cap_row_q;
        row_d     = row_q;
        col_d     = col_q;
        valid_d   = valid_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        case (state_q)
            SCAN: begin
                if (scan_hit) begin
                    dwell_d = CNT_ZERO;
                    if (one_cold4(rs)) begin
                        cap_row_d = rs;
                        deb_d     = CNT_ZERO;
                    end else begin
                        kp_col_d = rotate_col(kp_col_q);
                    end
                end else begin
                    dwell_d = dwell_q + CNT_ONE;
                end
            end
            DEBOUNCE: begin
                if (!match_cap) begin
                    kp_col_d = rotate_col(kp_col_q);
                    dwell_d  = CNT_ZERO;
                    deb_d    = CNT_ZERO;
                end else if (deb_hit) begin
                    row_d   = cap_row_q;
                    col_d   = kp_col_q;
                    valid_d = 1'b1;
                    deb_d   = CNT_ZERO;
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (!rs_idle) begin
                    deb_d = CNT_ZERO;
                end else if (deb_hit) begin
                    row_d    = KEY_IDLE;
                    col_d    = KEY_IDLE;
                    valid_d  = 1'b0;
                    deb_d    = CNT_ZERO;
                    dwell_d  = CNT_ZERO;
                    kp_col_d = rotate_col(kp_col_q);
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end
            end
            default: begin
                kp_col_d = COL_RESET;
                row_d    = KEY_IDLE;
                col_d    = KEY_IDLE;
                valid_d  = 1'b0;
                dwell_d  = CNT_ZERO;
                deb_d    = CNT_ZERO;
            end
        endcase
    end

    assign kp_col = kp_col_q;
    assign row    = row_q;
    assign col    = col_q;
    assign valid  = valid_q;

`ifdef KEYSCAN_STROBE_EN
    logic strobe_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) strobe_q <= 1'b0;
        else        strobe_q <= accept;
    end

    assign key_strobe = strobe_q;
`endif

endmodule

// File: tb/tb_keypad_scan_zyq.sv
// tb/tb_keypad_scan_zyq.sv - directed self-checking bench for keypad_scan_zyq (SCAN_DIV=4, DEBOUNCE_CNT=8)
module tb_keypad_scan_zyq;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] kp_row;
    logic [3:0] kp_col;
    logic [3:0] row;
    logic [3:0] col;
    logic       valid;
`ifdef KEYSCAN_STROBE_EN
    logic       key_strobe;
`endif

    logic       key_on  = 1'b0;
    logic [3:0] key_row = 4'hF;
    logic [3:0] key_col = 4'hF;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    // Keypad model: the pressed row pulls low only while its column is driven.
    always_comb kp_row = (key_on && (kp_col == key_col)) ? key_row : 4'hF;

    keypad_scan_zyq #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8),
        .CW           (8)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .kp_row (kp_row),
        .kp_col (kp_col),
        .row    (row),
        .col    (col),
        .valid  (valid)
`ifdef KEYSCAN_STROBE_EN
        ,
        .key_strobe (key_strobe)
`endif
    );

    task automatic do_reset();
        key_on = 1'b0;
        RST_N  = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (valid !== 1'b1 && cycles < limit) begin
            @(negedge CLK);
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (kp_col !== 4'hE) begin
            tests_failed++;
            $display("FAIL reset_kp_col got %b want 1110", kp_col);
        end
        tests_run++;
        if (row !== 4'hF || col !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_rowcol got %b/%b want 1111/1111", row, col);
        end
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid got %b want 0", valid);
        end
`ifdef KEYSCAN_STROBE_EN
        tests_run++;
        if (key_strobe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobe got %b want 0", key_strobe);
        end
`endif
    endtask

    task automatic test_idle_scan();
        logic [3:0] pat [4];
        pat = '{4'hE, 4'hD, 4'hB, 4'h7};
        do_reset();
        for (int k = 0; k < 64; k++) begin
            tests_run++;
            if (kp_col !== pat[(k / 4) % 4]) begin
                tests_failed++;
                $display("FAIL idle_kp_col k=%0d got %b want %b", k, kp_col, pat[(k / 4) % 4]);
            end
            tests_run++;
            if (valid !== 1'b0 || row !== 4'hF || col !== 4'hF) begin
                tests_failed++;
                $display("FAIL idle_outputs k=%0d got v=%b %b/%b want v=0 1111/1111", k, valid, row, col);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_press();
        int cyc;
        do_reset();
        key_row = 4'hB;
        key_col = 4'hB;
        key_on  = 1'b1;
        wait_valid(40, cyc);
        tests_run++;
        if (valid !== 1'b1 || cyc > 26) begin
            tests_failed++;
            $display("FAIL press_latency got v=%b after %0d cycles want v=1 within 26", valid, cyc);
        end
        tests_run++;
        if (row !== 4'hB || col !== 4'hB) begin
            tests_failed++;
            $display("FAIL press_key got %b/%b want 1011/1011", row, col);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            tests_run++;
            if (kp_col !== 4'hB || valid !== 1'b1 || row !== 4'hB) begin
                tests_failed++;
                $display("FAIL hold_frozen i=%0d got col=%b v=%b row=%b want 1011/1/1011", i, kp_col, valid, row);
            end
        end
        key_on = 1'b0;
        repeat (9) @(negedge CLK);
        tests_run++;
        if (valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_early got v=%b want 1 at 9 cycles", valid);
        end
        @(negedge CLK);
        tests_run++;
        if (valid !== 1'b0 || row !== 4'hF || col !== 4'hF) begin
            tests_failed++;
            $display("FAIL release_idle got v=%b %b/%b want 0 1111/1111 at 10 cycles", valid, row, col);
        end
        tests_run++;
        if (kp_col !== 4'h7) begin
            tests_failed++;
            $display("FAIL release_advance got %b want 0111", kp_col);
        end
    endtask

    task automatic test_bounce();
        int cyc;
        do_reset();
        key_row = 4'hB;
        key_col = 4'hB;
        for (int i = 0; i < 40; i++) begin
            key_on = ((i / 3) % 2) == 0;
            @(negedge CLK);
            tests_run++;
            if (valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL bounce_valid i=%0d got %b want 0", i, valid);
            end
        end
        key_on = 1'b1;
        wait_valid(60, cyc);
        tests_run++;
        if (valid !== 1'b1 || cyc < 10 || cyc > 26) begin
            tests_failed++;
            $display("FAIL bounce_settle got v=%b after %0d cycles want v=1 in 10..26", valid, cyc);
        end
        key_on = 1'b0;
    endtask

    task automatic test_multikey();
        int changes;
        logic [3:0] prev;
        do_reset();
        key_row = 4'h9;
        key_col = 4'hB;
        key_on  = 1'b1;
        changes = 0;
        prev    = kp_col;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (kp_col != prev) changes++;
            prev = kp_col;
            tests_run++;
            if (valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL multikey_valid i=%0d got %b want 0", i, valid);
            end
        end
        tests_run++;
        if (changes != 20) begin
            tests_failed++;
            $display("FAIL multikey_scan got %0d column steps want 20", changes);
        end
        key_on = 1'b0;
    endtask

    task automatic test_second_key();
        int cyc;
        do_reset();
        key_row = 4'hB;
        key_col = 4'hB;
        key_on  = 1'b1;
        wait_valid(40, cyc);
        key_row = 4'h9;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            tests_run++;
            if (valid !== 1'b1 || row !== 4'hB || col !== 4'hB || kp_col !== 4'hB) begin
                tests_failed++;
                $display("FAIL second_key i=%0d got v=%b %b/%b kc=%b want 1 1011/1011 1011", i, valid, row, col, kp_col);
            end
        end
        key_on = 1'b0;
        repeat (12) @(negedge CLK);
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL second_key_release got %b want 0", valid);
        end
    endtask

    task automatic test_reset_in_hold();
        int cyc;
        do_reset();
        key_row = 4'hB;
        key_col = 4'hB;
        key_on  = 1'b1;
        wait_valid(40, cyc);
        tests_run++;
        if (valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_hold_reach got %b want 1", valid);
        end
        RST_N = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (valid !== 1'b0 || row !== 4'hF || col !== 4'hF || kp_col !== 4'hE) begin
            tests_failed++;
            $display("FAIL rst_hold got v=%b %b/%b kc=%b want 0 1111/1111 1110", valid, row, col, kp_col);
        end
        RST_N  = 1'b1;
        key_on = 1'b0;
    endtask

`ifdef KEYSCAN_STROBE_EN
    task automatic test_strobe();
        int   pulses;
        logic prev_v;
        do_reset();
        key_row = 4'hD;
        key_col = 4'hD;
        key_on  = 1'b1;
        pulses  = 0;
        prev_v  = valid;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            tests_run++;
            if (key_strobe !== (valid && !prev_v)) begin
                tests_failed++;
                $display("FAIL strobe_edge i=%0d got %b want %b", i, key_strobe, valid && !prev_v);
            end
            if (key_strobe === 1'b1) pulses++;
            prev_v = valid;
        end
        tests_run++;
        if (pulses != 1 || valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL strobe_count got %0d pulses v=%b want 1 pulse v=1", pulses, valid);
        end
        key_on = 1'b0;
    endtask
`endif

    initial begin
        RST_N = 1'b0;
        test_reset();
        test_idle_scan();
        test_press();
        test_bounce();
        test_multikey();
        test_second_key();
        test_reset_in_hold();
`ifdef KEYSCAN_STROBE_EN
        test_strobe();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
